// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache sitting
// between the CPU load/store path and main data memory.
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   READ, WRITE         CPU load / store request (never both high)
//   ADDRESS[7:0]        CPU byte address = {tag, index, offset}
//   WRITEDATA[7:0]      store data
//   READDATA[7:0]       load data (combinational on a hit, otherwise holds)
//   BUSYWAIT            CPU stall while a miss is being serviced
//   MEM_READ/MEM_WRITE  block read / write-back request to memory
//   MEM_ADDRESS[5:0]    block address = {tag, index}
//   MEM_WRITEDATA[31:0] evicted block, byte 0 in [7:0]
//   MEM_READDATA[31:0]  fetched block, byte 0 in [7:0]
//   MEM_BUSYWAIT        memory busy; transfer done when low with request held
//
// Optional feature (macro DCACHE_STATS_EN): adds saturating 16-bit
// HIT_COUNT / MISS_COUNT outputs. With the macro undefined they are absent.
module data_cache #(
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);

  localparam int TAG_BITS = 6 - INDEX_BITS;
  localparam int NBLK     = 1 << INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_MEM_WRITE} state_t;

  state_t                state_q, state_d;
  logic [NBLK-1:0]       valid_q, valid_d;
  logic [NBLK-1:0]       dirty_q, dirty_d;
  logic [TAG_BITS-1:0]   tag_q  [NBLK];
  logic [TAG_BITS-1:0]   tag_d  [NBLK];
  logic [31:0]           data_q [NBLK];
  logic [31:0]           data_d [NBLK];
  logic [7:0]            readdata_q, readdata_d;

  logic [TAG_BITS-1:0]   addr_tag;
  logic [INDEX_BITS-1:0] addr_idx;
  logic [4:0]            byte_lsb;
  logic                  req;
  logic                  hit;

  assign addr_tag = ADDRESS[7 -: TAG_BITS];
  assign addr_idx = ADDRESS[OFFSET_BITS +: INDEX_BITS];
  assign byte_lsb = {ADDRESS[OFFSET_BITS-1:0], 3'b000};
  assign req      = READ | WRITE;
  assign hit      = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    tag_d         = tag_q;
    data_d        = data_q;
    readdata_d    = readdata_q;
    READDATA      = readdata_q;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            // A miss that has just been filled also completes here, as a hit.
            if (READ) begin
              READDATA   = data_q[addr_idx][byte_lsb +: 8];
              readdata_d = data_q[addr_idx][byte_lsb +: 8];
            end
            if (WRITE) begin
              data_d[addr_idx][byte_lsb +: 8] = WRITEDATA;
              dirty_d[addr_idx]               = 1'b1;
            end
          end else begin
            BUSYWAIT = 1'b1;
            state_d  = (valid_q[addr_idx] && dirty_q[addr_idx]) ? S_MEM_WRITE : S_MEM_READ;
          end
        end
      end
      S_MEM_WRITE: begin
        // Write back the resident block under its own stored tag.
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[addr_idx], addr_idx};
        MEM_WRITEDATA = data_q[addr_idx];
        if (!MEM_BUSYWAIT) state_d = S_MEM_READ;
      end
      S_MEM_READ: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {addr_tag, addr_idx};
        if (!MEM_BUSYWAIT) begin
          data_d[addr_idx]  = MEM_READDATA;
          tag_d[addr_idx]   = addr_tag;
          valid_d[addr_idx] = 1'b1;
          dirty_d[addr_idx] = 1'b0;
          state_d           = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      readdata_q <= readdata_d;
    end
  end

  // Tag and data arrays are qualified by valid, so they need no reset.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

`ifdef DCACHE_STATS_EN
  logic        retry_q, retry_d;
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  always_comb begin
    // retry marks the IDLE cycle right after a fill, whose hit is not counted.
    retry_d      = (state_q == S_MEM_READ) && !MEM_BUSYWAIT;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == S_IDLE && req) begin
      if (hit && !retry_q && hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
      if (!hit && miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      retry_q      <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      retry_q      <= retry_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign HIT_COUNT  = hit_count_q;
  assign MISS_COUNT = miss_count_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios followed by random
// loads/stores, compared against a block-level cache + memory reference model.
module tb_data_cache;
  logic        CLK = 1'b0;
  logic        RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA = 32'h0;
  logic        MEM_BUSYWAIT = 1'b1;
`ifdef DCACHE_STATS_EN
  logic [15:0] HIT_COUNT, MISS_COUNT;
`endif

  data_cache dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Backing memory seen by the DUT, and the reference copy the model uses.
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  // Reference cache model.
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [2:0]  m_tag   [8];
  logic [31:0] m_blk   [8];
  logic [15:0] m_hits, m_misses;
  logic [7:0]  last_rd;

  bit mem_stall = 1'b0;
  int lat_cnt   = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits   = '0;
    m_misses = '0;
    last_rd  = '0;
  endtask

  // Memory with random latency; completes a transfer by dropping busy.
  always @(negedge CLK) begin
    check("mem_excl", {31'b0, MEM_READ && MEM_WRITE}, 32'h0);
    if ((MEM_READ || MEM_WRITE) && !mem_stall) begin
      if (lat_cnt < 0) lat_cnt = $urandom_range(0, 3);
      if (lat_cnt == 0) begin
        MEM_BUSYWAIT = 1'b0;
        if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
        else MEM_READDATA = mem[MEM_ADDRESS];
        lat_cnt = -1;
      end else begin
        MEM_BUSYWAIT = 1'b1;
        lat_cnt--;
      end
    end else begin
      MEM_BUSYWAIT = 1'b1;
      if (!mem_stall) lat_cnt = -1;
    end
  end

  // Called just after a rising edge; returns just after the completing edge.
  task automatic do_req(input bit rd, input logic [7:0] a, input logic [7:0] wd,
                        output logic [7:0] rdata, output logic [5:0] ev_a,
                        output logic [31:0] ev_d, output logic [5:0] fill_a);
    logic [2:0]  idx, tg;
    int          o, nw, nr, cyc, fill_cyc;
    bit          exp_hit, exp_ev, done;
    logic [5:0]  exp_ev_a, exp_fill_a;
    logic [31:0] exp_ev_d;
    logic [7:0]  exp_rd;
    idx = a[4:2];
    tg  = a[7:5];
    o   = int'(a[1:0]) * 8;
    exp_hit    = m_valid[idx] && (m_tag[idx] == tg);
    exp_ev     = !exp_hit && m_valid[idx] && m_dirty[idx];
    exp_ev_a   = {m_tag[idx], idx};
    exp_ev_d   = m_blk[idx];
    exp_fill_a = {tg, idx};
    if (exp_hit) begin
      if (m_hits != 16'hFFFF) m_hits++;
    end else begin
      if (m_misses != 16'hFFFF) m_misses++;
      if (exp_ev) ref_mem[exp_ev_a] = m_blk[idx];
      m_blk[idx]   = ref_mem[exp_fill_a];
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    exp_rd = m_blk[idx][o +: 8];
    if (rd) last_rd = exp_rd;
    else begin
      m_blk[idx][o +: 8] = wd;
      m_dirty[idx] = 1'b1;
    end

    READ = rd; WRITE = !rd; ADDRESS = a; WRITEDATA = wd;
    rdata = '0; ev_a = '0; ev_d = '0; fill_a = '0;
    nw = 0; nr = 0; cyc = 0; fill_cyc = -10; done = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge CLK); #1;
      if (cyc == 0) check("first_cycle_stall", {31'b0, BUSYWAIT}, {31'b0, !exp_hit});
      if (MEM_WRITE && !MEM_BUSYWAIT) begin
        check("evict_addr", {26'b0, MEM_ADDRESS}, {26'b0, exp_ev_a});
        check("evict_data", MEM_WRITEDATA, exp_ev_d);
        ev_a = MEM_ADDRESS; ev_d = MEM_WRITEDATA; nw++;
      end
      if (MEM_READ && !MEM_BUSYWAIT) begin
        check("fill_addr", {26'b0, MEM_ADDRESS}, {26'b0, exp_fill_a});
        fill_a = MEM_ADDRESS; nr++; fill_cyc = cyc;
      end
      if (!BUSYWAIT) begin
        done = 1'b1;
        if (!exp_hit) check("fill_to_done_cycles", cyc - fill_cyc, 1);
        if (rd) begin
          rdata = READDATA;
          check("readdata", {24'b0, READDATA}, {24'b0, exp_rd});
        end
      end
      @(posedge CLK); #1;
      cyc++;
    end
    READ = 1'b0; WRITE = 1'b0;
    if (!done) check("req_timeout", 32'h0, 32'h1);
    check("n_evict", nw, {31'b0, exp_ev});
    check("n_fill", nr, {31'b0, !exp_hit});
`ifdef DCACHE_STATS_EN
    check("hit_count", {16'b0, HIT_COUNT}, {16'b0, m_hits});
    check("miss_count", {16'b0, MISS_COUNT}, {16'b0, m_misses});
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK); #1;
      check("readdata_hold", {24'b0, READDATA}, {24'b0, last_rd});
      check("idle_no_mem_req", {30'b0, MEM_READ, MEM_WRITE}, 32'h0);
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  rd, a;
    logic [5:0]  ea, fa;
    logic [31:0] ed;
    bit          seen;
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h44332211;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    @(negedge CLK); #1;
    check("rst_busywait", {31'b0, BUSYWAIT}, 32'h0);
    check("rst_mem_read", {31'b0, MEM_READ}, 32'h0);
    check("rst_mem_write", {31'b0, MEM_WRITE}, 32'h0);
    check("rst_mem_address", {26'b0, MEM_ADDRESS}, 32'h0);
    check("rst_mem_writedata", MEM_WRITEDATA, 32'h0);
    check("rst_readdata", {24'b0, READDATA}, 32'h0);
`ifdef DCACHE_STATS_EN
    check("rst_hit_count", {16'b0, HIT_COUNT}, 32'h0);
    check("rst_miss_count", {16'b0, MISS_COUNT}, 32'h0);
`endif
    @(posedge CLK); #1;

    // Directed scenarios.
    do_req(1'b1, 8'h00, 8'h00, rd, ea, ed, fa);
    check("cold_read_data", {24'b0, rd}, 32'h11);
    check("cold_fill_addr", {26'b0, fa}, 32'h00);
    do_req(1'b1, 8'h03, 8'h00, rd, ea, ed, fa);
    check("hit_read_byte3", {24'b0, rd}, 32'h44);
    do_req(1'b0, 8'h01, 8'hAA, rd, ea, ed, fa);
    do_req(1'b1, 8'h01, 8'h00, rd, ea, ed, fa);
    check("read_after_write", {24'b0, rd}, 32'hAA);
    do_req(1'b1, 8'h20, 8'h00, rd, ea, ed, fa);
    check("dirty_evict_addr", {26'b0, ea}, 32'h00);
    check("dirty_evict_data", ed, 32'h4433AA11);
    check("refill_addr", {26'b0, fa}, 32'h08);
    check("refill_byte0", {24'b0, rd}, {24'b0, mem[8][7:0]});
    do_req(1'b0, 8'h45, 8'h5C, rd, ea, ed, fa);
    check("store_miss_fill_addr", {26'b0, fa}, 32'h11);
    do_req(1'b1, 8'h45, 8'h00, rd, ea, ed, fa);
    check("store_miss_byte", {24'b0, rd}, 32'h5C);
    idle(2);

    // Random traffic, biased toward few tags to mix hits and evictions.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      a = 8'($urandom);
      if ($urandom_range(0, 1) == 1) a[7:6] = 2'b00;
      if ($urandom_range(0, 1) == 1) a[4] = 1'b0;
      do_req(1'($urandom_range(0, 1)), a, 8'($urandom), rd, ea, ed, fa);
    end

    // Reset during a stalled block read.
    RESET = 1'b1;
    @(posedge CLK); #1 RESET = 1'b0;
    model_reset();
    mem_stall = 1'b1;
    READ = 1'b1; ADDRESS = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge CLK); #1;
      if (MEM_READ) seen = 1'b1;
      else begin
        @(posedge CLK); #1;
      end
    end
    check("abort_mem_read_seen", {31'b0, seen}, 32'h1);
    @(posedge CLK); #1;
    RESET = 1'b1; READ = 1'b0;
    @(posedge CLK); #1 RESET = 1'b0;
    @(negedge CLK); #1;
    check("abort_mem_read", {31'b0, MEM_READ}, 32'h0);
    check("abort_busywait", {31'b0, BUSYWAIT}, 32'h0);
    check("abort_readdata", {24'b0, READDATA}, 32'h0);
    mem_stall = 1'b0;
    @(posedge CLK); #1;
    model_reset();
    do_req(1'b1, 8'h00, 8'h00, rd, ea, ed, fa);
    check("post_reset_refill_addr", {26'b0, fa}, 32'h00);
    check("post_reset_read", {24'b0, rd}, {24'b0, ref_mem[0][7:0]});
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU load/store path and main data memory.
- Produces READDATA, which the register write-select stage selects when a load completes.
- Stalls the CPU via BUSYWAIT on misses.
- Fills or evicts whole 4-byte blocks through a 32-bit memory port that has its own busywait handshake.

Parameters:
- INDEX_BITS, 3, log2 of block count (default 8 blocks); TAG_BITS = 6 - INDEX_BITS.
- OFFSET_BITS, 2, byte offset within a block; fixed at 2 (4-byte block).

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- READ  input  1  CPU load request.
- WRITE  input  1  CPU store request; READ and WRITE are never both high.
- ADDRESS  input  8  CPU byte address = {tag, index, offset}.
- WRITEDATA  input  8  store data.
- READDATA  output  8  load data to the register write-select stage.
- BUSYWAIT  output  1  CPU stall request.
- MEM_READ  output  1  memory block read request.
- MEM_WRITE  output  1  memory block write request.
- MEM_ADDRESS  output  6  memory block address = {tag, index}.
- MEM_WRITEDATA  output  32  evicted block, byte 0 in bits [7:0].
- MEM_READDATA  input  32  fetched block, byte 0 in bits [7:0].
- MEM_BUSYWAIT  input  1  memory busy; a transfer is complete when this is low while a request is held.

Behaviour:
- Per block storage: valid bit, dirty bit, TAG_BITS tag, 32-bit data.
- hit = valid[index] && (tag[index] == ADDRESS tag); combinational.
- States: IDLE, MEM_READ, MEM_WRITE.
- Reset:
  - state = IDLE; all valid = 0, dirty = 0.
  - Outputs: BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0.
  - Data array contents are don't-care.
  - Reset mid-transfer aborts the transfer and drops memory requests on the next cycle.
- IDLE:
  - READ hit: READDATA = selected byte, combinational, same cycle; BUSYWAIT=0; no state change.
  - WRITE hit: BUSYWAIT=0; on the clock edge the byte is written and dirty is set.
  - Miss, block not dirty: BUSYWAIT=1 combinationally; next state MEM_READ.
  - Miss, block dirty (valid and dirty): BUSYWAIT=1; next state MEM_WRITE.
  - No request: BUSYWAIT=0; READDATA holds the last driven value.
- MEM_WRITE:
  - MEM_WRITE=1, MEM_ADDRESS={stored tag, index}, MEM_WRITEDATA=stored block; BUSYWAIT=1.
  - When MEM_BUSYWAIT=0: next state MEM_READ.
- MEM_READ:
  - MEM_READ=1, MEM_ADDRESS={ADDRESS tag, index}; BUSYWAIT=1.
  - When MEM_BUSYWAIT=0, at the clock edge: data = MEM_READDATA, tag updated, valid=1, dirty=0; next state IDLE.
- Miss resolution:
  - Back in IDLE, the still-held request now hits and completes as a normal hit the same cycle, with BUSYWAIT falling.
  - Store miss therefore completes with dirty=1 after the fill.
- MEM_READ and MEM_WRITE are never high together. Memory requests are deasserted in IDLE.
- Miss penalty = memory latency of one block read (clean) or of a write plus a read (dirty), plus 1 cycle to return to IDLE.
- The CPU holds READ/WRITE/ADDRESS/WRITEDATA stable while BUSYWAIT=1. Behaviour if the request drops mid-miss: the current transfer completes, then the cache returns to IDLE.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined:
  - Adds outputs HIT_COUNT[15:0] and MISS_COUNT[15:0], both reset to 0.
  - HIT_COUNT increments once per request completing on a first-cycle hit.
  - MISS_COUNT increments once per IDLE-to-miss transition; retry hits after a fill are not counted as hits.
  - Both counters saturate at 16'hFFFF.
- Undefined: ports and logic absent; all other behaviour is identical.

Test Plan:
- Reset, then READ ADDRESS=8'h00 -> BUSYWAIT=1 and MEM_READ=1 with MEM_ADDRESS=6'h00; memory returns 32'h44332211 -> READDATA=8'h11, BUSYWAIT=0; MISS_COUNT=1.
- After previous, READ 8'h03 -> hit same cycle, READDATA=8'h44, no MEM_READ; HIT_COUNT=1.
- WRITE 8'h01 data 8'hAA (hit) -> no stall; then READ 8'h01 -> 8'hAA; dirty[0]=1.
- READ 8'h20 (same index 0, tag 1) -> MEM_WRITE with MEM_ADDRESS=6'h00 and MEM_WRITEDATA=32'h4433AA11, then MEM_READ with MEM_ADDRESS=6'h08; fill completes -> READDATA = byte 0 of new block.
- WRITE miss 8'h45 data 8'h5C to a clean invalid block -> fill of MEM_ADDRESS=6'h11, then byte 1 = 8'h5C, dirty=1, BUSYWAIT low one cycle after fill.
- RESET asserted during MEM_READ with MEM_BUSYWAIT=1 -> next cycle MEM_READ=0, BUSYWAIT=0; subsequent READ 8'h00 misses again (valid cleared).
